// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: ALU widths, opcodes and FSM states.
package alu_cmd_sequencer_pkg;

    localparam int DATA_W = 4;
    localparam int RES_W  = 5;
    localparam int OP_W   = 2;

    localparam logic [OP_W-1:0] ALU_OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] ALU_OP_SUB = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Clocked, back-pressurable front end for the combinational 4-bit ALU: registers a command,
// waits a settle interval, captures the ALU result and offers it downstream.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [RES_W-1:0]  alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic [OP_W-1:0]   rsp_op,
    output logic              busy,
    output logic [CNT_W-1:0]  cmd_count
);

    // A settle interval of 0 behaves like 1: the result is always sampled at least one edge
    // after the operands are registered.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int SCNT_W     = ($clog2(SETTLE_EFF) > 0) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_EFF - 1);

    state_t            state;
    state_t            state_next;
    logic [SCNT_W-1:0] settle_cnt;
    logic              accept;
    logic              settle_done;
    logic              rsp_done;

    assign cmd_ready   = (state == IDLE);
    assign busy        = ~cmd_ready;
    assign accept      = cmd_valid && cmd_ready;
    assign settle_done = (state == SETTLE) && (settle_cnt == '0);
    assign rsp_done    = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)      state_next = SETTLE;
            SETTLE:  if (settle_done) state_next = RESP;
            RESP:    if (rsp_done)    state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Operands stay on the ALU lines after completion; only a new command replaces them.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_op     <= '0;
            settle_cnt <= '0;
        end else if (accept) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_op     <= cmd_op;
            rsp_op     <= cmd_op;
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            cmd_count  <= '0;
        end else if (settle_done) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
        end else if (rsp_done) begin
            rsp_valid  <= 1'b0;
            cmd_count  <= cmd_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: two sequencer instances (settle 1 / 8-bit count, settle 3 / 2-bit count)
// each driving a behavioural ALU, with randomized commands and back-pressure.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    typedef struct {
        logic [4:0] res;
        logic [1:0] op;
        time        t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (inst %0d) at %0t: got %0d, required %0d", name, g, $time, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int g);
        n_chk++;
        n_fail++;
        $display("FAIL %s (inst %0d) at %0t", name, g, $time);
    endtask

    // Reference ALU behaviour: 5-bit results, add/sub wrap modulo 32.
    function automatic logic [4:0] alu_ref(input int a, input int b, input int op);
        case (op)
            0:       return 5'((a + b) % 32);
            1:       return 5'((a - b + 32) % 32);
            2:       return 5'(a & b);
            default: return 5'(a ^ b);
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int S  = (g == 0) ? 1 : 3;
        localparam int CW = (g == 0) ? 8 : 2;

        logic          rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
        logic [3:0]    cmd_a, cmd_b, alu_a, alu_b;
        logic [1:0]    cmd_op, alu_op, rsp_op;
        logic [4:0]    alu_result, rsp_result;
        logic [CW-1:0] cmd_count;

        exp_t       exp_q[$];
        bit         armed = 0, rst_pend = 0, pend_hs = 0, in_rsp = 0, done = 0;
        int         model_count = 0;
        logic [4:0] hold_res;
        logic [1:0] hold_op;
        int         rdy_mode = 0;
        bit         man_rdy = 0;
        time        acc_t;
        int         n_done_cmds = 0;

        always_comb begin
            case (alu_op)
                ALU_OP_ADD: alu_result = {1'b0, alu_a} + {1'b0, alu_b};
                ALU_OP_SUB: alu_result = {1'b0, alu_a} - {1'b0, alu_b};
                2'b10:      alu_result = {1'b0, alu_a & alu_b};
                default:    alu_result = {1'b0, alu_a ^ alu_b};
            endcase
        end

        alu_cmd_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
            .clk(clk), .rst(rst),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
            .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
            .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
            .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
            .rsp_result(rsp_result), .rsp_op(rsp_op),
            .busy(busy), .cmd_count(cmd_count)
        );

        // Monitor: compares outputs against the scoreboard queue and the model's idle/count view.
        always @(negedge clk) begin : mon
            exp_t e;
            bit   idle;
            if (rst_pend) begin
                exp_q.delete();
                in_rsp = 0;
                pend_hs = 0;
                model_count = 0;
                armed = 1;
                check("reset alu_a", g, 32'(alu_a), 0);
                check("reset alu_b", g, 32'(alu_b), 0);
                check("reset alu_op", g, 32'(alu_op), 0);
                check("reset rsp_valid", g, 32'(rsp_valid), 0);
                check("reset rsp_result", g, 32'(rsp_result), 0);
                check("reset rsp_op", g, 32'(rsp_op), 0);
                check("reset cmd_count", g, 32'(cmd_count), 0);
            end
            rst_pend = rst;
            if (armed) begin
                if (pend_hs) begin
                    model_count++;
                    pend_hs = 0;
                end
                idle = (exp_q.size() == 0) && !in_rsp;
                check("cmd_ready", g, 32'(cmd_ready), 32'(idle));
                check("busy", g, 32'(busy), 32'(!idle));
                check("cmd_count", g, 32'(cmd_count), 32'(model_count % (1 << CW)));
                if (rsp_valid) begin
                    if (!in_rsp) begin
                        if (exp_q.size() == 0) begin
                            fail_now("unexpected rsp_valid", g);
                            hold_res = rsp_result;
                            hold_op = rsp_op;
                        end else begin
                            e = exp_q.pop_front();
                            check("rsp_result", g, 32'(rsp_result), 32'(e.res));
                            check("rsp_op", g, 32'(rsp_op), 32'(e.op));
                            check("rsp latency", g, 32'($time - e.t), 32'(S * 10 + 5));
                            hold_res = e.res;
                            hold_op = e.op;
                        end
                        in_rsp = 1;
                    end else begin
                        check("held rsp_result", g, 32'(rsp_result), 32'(hold_res));
                        check("held rsp_op", g, 32'(rsp_op), 32'(hold_op));
                    end
                    if (rsp_ready) begin
                        pend_hs = 1;
                        in_rsp = 0;
                    end
                end else if (in_rsp) begin
                    fail_now("rsp_valid dropped without handshake", g);
                    in_rsp = 0;
                end
            end
        end

        initial begin
            rsp_ready = 1'b0;
            forever begin
                @(posedge clk);
                #2;
                case (rdy_mode)
                    0:       rsp_ready = 1'b1;
                    1:       rsp_ready = ($urandom_range(0, 2) != 0);
                    default: rsp_ready = man_rdy;
                endcase
            end
        end

        task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
            int   n;
            exp_t e;
            n = 0;
            cmd_valid = 1'b1;
            cmd_a = a;
            cmd_b = b;
            cmd_op = op;
            @(negedge clk);
            while (!cmd_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!cmd_ready) begin
                fail_now("accept timeout", g);
                cmd_valid = 1'b0;
                return;
            end
            @(posedge clk);
            e.res = alu_ref(int'(a), int'(b), int'(op));
            e.op = op;
            e.t = $time;
            exp_q.push_back(e);
            acc_t = $time;
            n_done_cmds++;
            #1;
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            while ((exp_q.size() != 0 || in_rsp || pend_hs) && n < 300) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (exp_q.size() != 0 || in_rsp) fail_now("drain timeout", g);
        endtask

        initial begin : drv
            time t_prev;
            int  k;
            rst = 1'b1;
            cmd_valid = 1'b0;
            cmd_a = '0;
            cmd_b = '0;
            cmd_op = '0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (2) @(posedge clk);
            #1;

            // Reset while the command is settling: it must vanish without a response.
            send(4'd6, 4'd2, ALU_OP_ADD);
            n_done_cmds--;
            cmd_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (S + 4) @(posedge clk);
            #1;

            // Back-to-back commands with rsp_ready high: spacing is S+2 cycles.
            send(4'd5, 4'd3, ALU_OP_ADD);
            t_prev = acc_t;
            send(4'd5, 4'd3, ALU_OP_SUB);
            check("accept spacing", g, 32'(acc_t - t_prev), 32'((S + 2) * 10));
            t_prev = acc_t;
            send(4'd15, 4'd15, ALU_OP_ADD);
            check("accept spacing", g, 32'(acc_t - t_prev), 32'((S + 2) * 10));
            cmd_valid = 1'b0;
            wait_idle();

            // Back-pressure: response held 4 cycles while a new command waits.
            man_rdy = 1'b0;
            rdy_mode = 2;
            send(4'd9, 4'd4, ALU_OP_SUB);
            cmd_a = 4'd7;
            cmd_b = 4'd2;
            cmd_op = 2'b10;
            k = 0;
            while (!rsp_valid && k < 50) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (!rsp_valid) fail_now("rsp_valid timeout", g);
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            man_rdy = 1'b1;
            @(posedge clk);
            #1;
            man_rdy = 1'b0;
            send(4'd7, 4'd2, 2'b10);
            cmd_valid = 1'b0;
            rdy_mode = 0;
            wait_idle();

            // Randomized traffic with random back-pressure and idle gaps.
            rdy_mode = 1;
            for (int i = 0; i < 24; i++) begin
                send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
                if ($urandom_range(0, 1) != 0) begin
                    cmd_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
            cmd_valid = 1'b0;
            rdy_mode = 0;
            wait_idle();
            @(posedge clk);
            #1;
            check("final cmd_count", g, 32'(cmd_count), 32'(n_done_cmds % (1 << CW)));
            done = 1;
        end
    end

    initial begin : top
        int cyc;
        cyc = 0;
        while (!(inst[0].done && inst[1].done) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(inst[0].done && inst[1].done)) fail_now("overall timeout", -1);
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
